data_mem_access_ctrl: RTL and testbench
=======================================

// Module: data_mem_access_ctrl
// PURPOSE
//  Initiator side of the data-memory/stack interface. Accepts one load/store/push/pop request from
//  the multicycle datapath (valid/ready), drives the memory's mem_write/mem_read/dataMemEnable
//  strobes for exactly one cycle, and returns the registered read data with a completion handshake.
//  Keeps a shadow stack count and rejects overflow/underflow/illegal addresses, because the memory drops these silently.
// PARAMETERS
//  DATA_MEM_SIZE  256  words in data memory; static word index must be < STACK_START
//  STACK_START    200  first stack word index; static accesses at/above it are illegal
//  STACK_SIZE     56   stack span; STACK_DEPTH = STACK_SIZE/4 = 14 entries (localparam)
// PORTS
//  clk            in   1   rising-edge clock, shared with data memory
//  reset_n        in   1   asynchronous active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   high only in IDLE
//  req_op         in   2   00 LOAD, 01 STORE, 10 PUSH, 11 POP
//  req_addr       in   32  byte address (LOAD/STORE only)
//  req_wdata      in   32  store/push data
//  rsp_valid      out  1   response present
//  rsp_ready      in   1   datapath accepts response
//  rsp_data       out  32  load/pop data; 0 for STORE/PUSH/errors
//  rsp_err        out  1   request rejected, no memory access made
//  mem_write      out  1   to memory
//  mem_read       out  1   to memory
//  dataMemEnable  out  1   1 = static access, 0 = stack access
//  mem_address    out  32  byte address to memory
//  mem_data_in    out  32  write data to memory
//  mem_data_out   in   32  registered read data from memory
//  stack_count    out  8   entries currently on stack (0..14)
//  stack_full     out  1   stack_count == STACK_DEPTH (combinational)
//  stack_empty    out  1   stack_count == 0 (combinational)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_data=0;
//   mem_write=mem_read=dataMemEnable=0; mem_address=mem_data_in=0; stack_count=0.
//   Memory's internal sp is NOT reset: reset_n only at power-up alongside memory init.
//  FSM: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE; IDLE -> RESP directly on error.
//  IDLE: on req_valid&&req_ready latch op/addr/wdata; evaluate error:
//   LOAD/STORE: addr[1:0]!=0 or addr[31:2] >= STACK_START -> error.
//   PUSH with stack_full, POP with stack_empty -> error.
//   Error: next state RESP with rsp_err=1, rsp_data=0; no strobe ever asserted.
//  ISSUE (1 cycle): exactly one of mem_write/mem_read high; dataMemEnable=1 for LOAD/STORE, 0 for
//   PUSH/POP; mem_address=addr, mem_data_in=wdata. Memory acts on the closing edge.
//   stack_count +1 on PUSH, -1 on POP at that same edge.
//  CAPTURE (1 cycle): strobes low; rsp_data <= mem_data_out for LOAD/POP, else 0.
//  RESP: rsp_valid=1, rsp_data/rsp_err held stable until rsp_valid&&rsp_ready; then IDLE.
//  Latency: legal request -> rsp_valid high 3 cycles after accept edge; error -> 1 cycle.
//  mem_write and mem_read never both high; both low outside ISSUE. One request outstanding max.
//  Reset mid-ISSUE: strobes drop immediately (async); memory outcome for that edge undefined.
// TESTING
//  1 STORE 0x0000_0005 @0x10, then LOAD @0x10 -> rsp_data=5, rsp_err=0, rsp_valid 3 cycles after accept.
//  2 PUSH 0xA, PUSH 0xB, POP, POP -> 0xB then 0xA; stack_count 1,2,1,0; dataMemEnable=0 in ISSUE.
//  3 POP after reset -> rsp_err=1 one cycle after accept, mem_read never high, stack_count stays 0.
//  4 14 PUSHes -> stack_full=1; 15th PUSH -> rsp_err=1, mem_write not asserted, count stays 14.
//  5 LOAD @0x6 and STORE @0x320 (word 200) -> rsp_err=1 each, no strobes.
//  6 rsp_ready low 4 cycles on a LOAD -> rsp_valid/rsp_data stable, req_ready=0; reset_n low in ISSUE -> strobes 0 same cycle.

Source files
------------

// File: rtl/data_mem_access_ctrl.sv
// Initiator-side controller for the shared data memory / stack: one request at a time,
// single-cycle memory strobes, shadow stack count and address/stack error rejection.
module data_mem_access_ctrl #(
    parameter int unsigned DATA_MEM_SIZE = 256,
    parameter int unsigned STACK_START   = 200,
    parameter int unsigned STACK_SIZE    = 56
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        mem_write,
    output logic        mem_read,
    output logic        dataMemEnable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic [7:0]  stack_count,
    output logic        stack_full,
    output logic        stack_empty
);

    localparam int unsigned STACK_DEPTH = STACK_SIZE / 4;
    // Static words must sit below the stack region and inside the memory.
    localparam int unsigned WORD_LIMIT  = (STACK_START < DATA_MEM_SIZE) ? STACK_START : DATA_MEM_SIZE;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        req_ready_d, rsp_valid_d, rsp_err_d;
    logic [31:0] rsp_data_d;
    logic        mem_write_d, mem_read_d, mem_en_d;
    logic [31:0] mem_address_d, mem_data_in_d;
    logic [7:0]  stack_count_d;
    logic        req_err_c;

    assign stack_full  = (stack_count == 8'(STACK_DEPTH));
    assign stack_empty = (stack_count == 8'd0);

    // Requests the memory would silently drop are rejected before any strobe.
    always_comb begin
        req_err_c = 1'b0;
        unique case (req_op)
            OP_LOAD, OP_STORE: req_err_c = (req_addr[1:0] != 2'b00) ||
                                           (req_addr[31:2] >= 30'(WORD_LIMIT));
            OP_PUSH:           req_err_c = stack_full;
            OP_POP:            req_err_c = stack_empty;
        endcase
    end

    // Next-state and next-output logic; strobes default low so they live only in ISSUE.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        req_ready_d   = req_ready;
        rsp_valid_d   = rsp_valid;
        rsp_err_d     = rsp_err;
        rsp_data_d    = rsp_data;
        mem_write_d   = 1'b0;
        mem_read_d    = 1'b0;
        mem_en_d      = 1'b0;
        mem_address_d = mem_address;
        mem_data_in_d = mem_data_in;
        stack_count_d = stack_count;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d          = req_op;
                    req_ready_d   = 1'b0;
                    mem_address_d = req_addr;
                    mem_data_in_d = req_wdata;
                    if (req_err_c) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 32'd0;
                    end else begin
                        state_d     = S_ISSUE;
                        mem_write_d = (req_op == OP_STORE) || (req_op == OP_PUSH);
                        mem_read_d  = (req_op == OP_LOAD)  || (req_op == OP_POP);
                        mem_en_d    = ~req_op[1];
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
                if (op_q == OP_PUSH) stack_count_d = stack_count + 8'd1;
                if (op_q == OP_POP)  stack_count_d = stack_count - 8'd1;
            end
            S_CAPTURE: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = ((op_q == OP_LOAD) || (op_q == OP_POP)) ? mem_data_out : 32'd0;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            op_q          <= OP_LOAD;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_data      <= 32'd0;
            mem_write     <= 1'b0;
            mem_read      <= 1'b0;
            dataMemEnable <= 1'b0;
            mem_address   <= 32'd0;
            mem_data_in   <= 32'd0;
            stack_count   <= 8'd0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            req_ready     <= req_ready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_err       <= rsp_err_d;
            rsp_data      <= rsp_data_d;
            mem_write     <= mem_write_d;
            mem_read      <= mem_read_d;
            dataMemEnable <= mem_en_d;
            mem_address   <= mem_address_d;
            mem_data_in   <= mem_data_in_d;
            stack_count   <= stack_count_d;
        end
    end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Bench for data_mem_access_ctrl: directed requests against a word-array/queue model,
// with a per-cycle compare process and literal checks on key results.
module tb_data_mem_access_ctrl;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;
    localparam int DEPTH = 14;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        mem_write, mem_read, dataMemEnable;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic [7:0]  stack_count;
    logic        stack_full, stack_empty;

    data_mem_access_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_write(mem_write), .mem_read(mem_read), .dataMemEnable(dataMemEnable),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .stack_count(stack_count), .stack_full(stack_full), .stack_empty(stack_empty)
    );

    always #5 clk = ~clk;

    // Memory environment: static words plus an internal stack pointer, registered read data.
    logic [31:0] ram [0:255];
    int          sp = 0;
    always @(posedge clk) begin
        if (mem_write && dataMemEnable) ram[mem_address[9:2]] <= mem_data_in;
        if (mem_read && dataMemEnable)  mem_data_out <= ram[mem_address[9:2]];
        if (mem_write && !dataMemEnable) begin
            ram[200 + sp] <= mem_data_in;
            sp <= sp + 1;
        end
        if (mem_read && !dataMemEnable) begin
            mem_data_out <= ram[200 + sp - 1];
            sp <= sp - 1;
        end
    end

    // Reference model: static memory contents and the stack as a queue.
    logic [31:0] mdl_mem [0:255];
    logic [31:0] mdl_stack [$];

    int total = 0;
    int bad   = 0;

    logic        chk_en = 1'b0;
    logic        e_wr = 1'b0, e_rd = 1'b0, e_en = 1'b0, e_rdy = 1'b1, e_rv = 1'b0, e_err = 1'b0;
    logic [31:0] e_data = 32'd0;
    int          e_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of DUT outputs against the expectations the driver maintains.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_write", 32'(mem_write), 32'(e_wr));
            chk("mem_read", 32'(mem_read), 32'(e_rd));
            if (e_wr || e_rd) chk("dataMemEnable", 32'(dataMemEnable), 32'(e_en));
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("stack_count", 32'(stack_count), 32'(e_cnt));
            chk("stack_full", 32'(stack_full), 32'(e_cnt == DEPTH));
            chk("stack_empty", 32'(stack_empty), 32'(e_cnt == 0));
            if (e_rv) begin
                chk("rsp_data", rsp_data, e_data);
                chk("rsp_err", 32'(rsp_err), 32'(e_err));
            end
        end
    end

    // One request end to end; returns the observed response and latency in cycles.
    task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, output logic [31:0] data, output logic err_o, output int lat);
        logic        err;
        logic [31:0] exp_d;
        int          k;
        err   = 1'b0;
        exp_d = 32'd0;
        lat   = 0;
        if (op == OP_LOAD || op == OP_STORE) err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd200);
        else if (op == OP_PUSH)              err = (mdl_stack.size() == DEPTH);
        else                                 err = (mdl_stack.size() == 0);
        if (!err && op == OP_LOAD) exp_d = mdl_mem[addr[9:2]];
        if (!err && op == OP_POP)  exp_d = mdl_stack[$];

        req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 1;
        if (!err) begin
            e_rdy = 1'b0;
            e_wr  = (op == OP_STORE) || (op == OP_PUSH);
            e_rd  = (op == OP_LOAD) || (op == OP_POP);
            e_en  = ~op[1];
            @(negedge clk); if (rsp_valid && lat == 0) lat = k;
            @(posedge clk); #1; k++;
            e_wr = 1'b0; e_rd = 1'b0;
            case (op)
                OP_STORE: mdl_mem[addr[9:2]] = wdata;
                OP_PUSH:  mdl_stack.push_back(wdata);
                OP_POP:   void'(mdl_stack.pop_back());
                default:  ;
            endcase
            e_cnt = mdl_stack.size();
            @(negedge clk); if (rsp_valid && lat == 0) lat = k;
            @(posedge clk); #1; k++;
        end
        e_rdy = 1'b0; e_rv = 1'b1; e_err = err; e_data = exp_d;
        @(negedge clk); if (rsp_valid && lat == 0) lat = k;
        data  = rsp_data;
        err_o = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        e_rv = 1'b0; e_err = 1'b0; e_rdy = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          l;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'd0;
            mdl_mem[i] = 32'd0;
        end
        mem_data_out = 32'd0;
        reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = OP_LOAD; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_strobes", {30'd0, mem_write, mem_read}, 32'd0);
        chk("rst_count", 32'(stack_count), 32'd0);
        chk("rst_empty", 32'(stack_empty), 32'd1);
        chk_en = 1'b1;

        // Store then load a static word
        do_req(OP_STORE, 32'h10, 32'h5, 0, d, e, l);
        chk("store_err", 32'(e), 32'd0);
        chk("store_lat", 32'(l), 32'd3);
        do_req(OP_LOAD, 32'h10, 32'h0, 0, d, e, l);
        chk("load_data", d, 32'h5);
        chk("load_err", 32'(e), 32'd0);
        chk("load_lat", 32'(l), 32'd3);

        // Pop on an empty stack
        do_req(OP_POP, 32'h0, 32'h0, 0, d, e, l);
        chk("underflow_err", 32'(e), 32'd1);
        chk("underflow_lat", 32'(l), 32'd1);
        chk("underflow_data", d, 32'd0);
        chk("underflow_cnt", 32'(stack_count), 32'd0);

        // LIFO order and count tracking
        do_req(OP_PUSH, 32'h0, 32'hA, 0, d, e, l);
        chk("push_a_cnt", 32'(stack_count), 32'd1);
        do_req(OP_PUSH, 32'h0, 32'hB, 0, d, e, l);
        chk("push_b_cnt", 32'(stack_count), 32'd2);
        do_req(OP_POP, 32'h0, 32'h0, 0, d, e, l);
        chk("pop_b_data", d, 32'hB);
        chk("pop_b_cnt", 32'(stack_count), 32'd1);
        do_req(OP_POP, 32'h0, 32'h0, 0, d, e, l);
        chk("pop_a_data", d, 32'hA);
        chk("pop_a_cnt", 32'(stack_count), 32'd0);

        // Misaligned and stack-region static addresses
        do_req(OP_LOAD, 32'h6, 32'h0, 0, d, e, l);
        chk("misalign_err", 32'(e), 32'd1);
        do_req(OP_STORE, 32'h320, 32'h77, 0, d, e, l);
        chk("stackreg_err", 32'(e), 32'd1);
        do_req(OP_STORE, 32'h31C, 32'h77, 0, d, e, l);
        chk("lastword_err", 32'(e), 32'd0);

        // Response back-pressure
        do_req(OP_STORE, 32'h44, 32'hDEADBEEF, 0, d, e, l);
        do_req(OP_LOAD, 32'h44, 32'h0, 4, d, e, l);
        chk("held_load_data", d, 32'hDEADBEEF);
        chk("held_rsp_data", rsp_data, 32'hDEADBEEF);

        // Fill the stack, then overflow
        for (int i = 0; i < DEPTH; i++) do_req(OP_PUSH, 32'h0, 32'h100 + 32'(i), 0, d, e, l);
        chk("full_flag", 32'(stack_full), 32'd1);
        do_req(OP_PUSH, 32'h0, 32'h999, 0, d, e, l);
        chk("overflow_err", 32'(e), 32'd1);
        chk("overflow_cnt", 32'(stack_count), 32'd14);

        // Reset asserted while a load is in ISSUE
        chk_en = 1'b0;
        req_op = OP_LOAD; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("issue_read", 32'(mem_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_read", 32'(mem_read), 32'd0);
        chk("rst_mid_write", 32'(mem_write), 32'd0);
        chk("rst_mid_en", 32'(dataMemEnable), 32'd0);
        chk("rst_mid_cnt", 32'(stack_count), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
